// File: rtl/bk_add_arbiter.sv
// Round-robin front end sharing one 16-bit Brent-Kung adder among N_REQ requesters.
// Operands are registered at grant; the adder settles for a full cycle before the sum is registered.

module Brent_Kung (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);

  logic [15:0] g;
  logic [15:0] p;
  logic [15:0] gg;
  logic [15:0] pp;

  always_comb begin
    g  = a & b;
    p  = a ^ b;
    gg = g;
    pp = p;
    // Up-sweep: node i (i+1 a multiple of 2^(l+1)) absorbs the span ending at i-2^l.
    for (int unsigned l = 0; l < 4; l++) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (((i + 1) % (2 << l)) == 0) begin
          gg[4'(i)] = gg[4'(i)] | (pp[4'(i)] & gg[4'(i - (1 << l))]);
          pp[4'(i)] = pp[4'(i)] & pp[4'(i - (1 << l))];
        end
      end
    end
    // Down-sweep fills the remaining prefixes from the completed power-of-two spans.
    for (int unsigned k = 0; k < 3; k++) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if ((((i + 1) % (2 << (2 - k))) == (1 << (2 - k))) && ((i + 1) > (1 << (2 - k)))) begin
          gg[4'(i)] = gg[4'(i)] | (pp[4'(i)] & gg[4'(i - (1 << (2 - k)))]);
          pp[4'(i)] = pp[4'(i)] & pp[4'(i - (1 << (2 - k)))];
        end
      end
    end
    sum = p ^ {gg[14:0], 1'b0};
  end

endmodule

module bk_add_arbiter #(
  parameter int N_REQ = 4,
  parameter int IDW   = $clog2(N_REQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [16*N_REQ-1:0]   a_in,
  input  logic [16*N_REQ-1:0]   b_in,
  output logic [N_REQ-1:0]      grant,
  output logic [15:0]           sum_out,
  output logic                  sum_valid,
  output logic [IDW-1:0]        sum_id,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_t;

  localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};

  state_t            state_q, state_d;
  logic [N_REQ-1:0]  grant_q, grant_d;
  logic [15:0]       sum_q, sum_d;
  logic              sum_valid_q, sum_valid_d;
  logic [IDW-1:0]    sum_id_q, sum_id_d;
  logic              busy_q, busy_d;
  logic [15:0]       op_a_q, op_a_d;
  logic [15:0]       op_b_q, op_b_d;
  logic [IDW-1:0]    win_id_q, win_id_d;
  logic [IDW-1:0]    last_q, last_d;

  logic              found;
  logic [IDW-1:0]    win;
  int unsigned       idx;
  logic [15:0]       sel_a;
  logic [15:0]       sel_b;
  logic [15:0]       add_sum;

  Brent_Kung u_adder (
    .a   (op_a_q),
    .b   (op_b_q),
    .sum (add_sum)
  );

  // Search starts one past the last winner and wraps, so the first hit is the round-robin choice.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = 0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      idx = (32'(last_q) + k) % N_REQ;
      if (!found && req[IDW'(idx)]) begin
        found = 1'b1;
        win   = IDW'(idx);
      end
    end
  end

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (win == IDW'(i)) begin
        sel_a = a_in[16*i +: 16];
        sel_b = b_in[16*i +: 16];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    sum_d       = sum_q;
    sum_valid_d = sum_valid_q;
    sum_id_d    = sum_id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    win_id_d    = win_id_q;
    last_d      = last_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          op_a_d   = sel_a;
          op_b_d   = sel_b;
          grant_d  = ONE_HOT0 << win;
          win_id_d = win;
          last_d   = win;
          state_d  = CALC;
        end
      end
      CALC: begin
        grant_d     = '0;
        sum_d       = add_sum;
        sum_id_d    = win_id_q;
        sum_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        sum_valid_d = 1'b0;
        state_d     = IDLE;
      end
      default: begin
        grant_d     = '0;
        sum_valid_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      sum_id_q    <= '0;
      busy_q      <= 1'b0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      win_id_q    <= '0;
      last_q      <= IDW'(N_REQ - 1);
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      sum_id_q    <= sum_id_d;
      busy_q      <= busy_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      win_id_q    <= win_id_d;
      last_q      <= last_d;
    end
  end

  assign grant     = grant_q;
  assign sum_out   = sum_q;
  assign sum_valid = sum_valid_q;
  assign sum_id    = sum_id_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bk_add_arbiter.sv
// Scoreboard bench for bk_add_arbiter with N_REQ=4: expected sums queued at issue, popped on sum_valid.

module tb_bk_add_arbiter;

  localparam int N = 4;

  logic          clk;
  logic          rst;
  logic [N-1:0]  req;
  logic [16*N-1:0] a_in;
  logic [16*N-1:0] b_in;
  logic [N-1:0]  grant;
  logic [15:0]   sum_out;
  logic          sum_valid;
  logic [1:0]    sum_id;
  logic          busy;

  typedef struct {
    int          id;
    logic [15:0] sum;
  } exp_t;

  exp_t sb[$];
  int   n_chk;
  int   n_bad;
  int   cyc;

  bk_add_arbiter #(.N_REQ(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a_in      (a_in),
    .b_in      (b_in),
    .grant     (grant),
    .sum_out   (sum_out),
    .sum_valid (sum_valid),
    .sum_id    (sum_id),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (sum_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(sum_valid), 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("sum_out", 32'(sum_out), 32'(e.sum));
        check("sum_id", 32'(sum_id), 32'(e.id));
      end
    end
  end

  task automatic set_ops(input int lane, input logic [15:0] a, input logic [15:0] b);
    a_in[16*lane +: 16] = a;
    b_in[16*lane +: 16] = b;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    req = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Called at a negedge with req already driven; w is the requester expected to win.
  task automatic issue(input int w, output int t_grant);
    exp_t e;
    e.id  = w;
    e.sum = 16'(a_in[16*w +: 16] + b_in[16*w +: 16]);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    t_grant = cyc;
    check("grant", 32'(grant), 32'(1) << w);
    check("busy_calc", 32'(busy), 32'd1);
    req[w] = 1'b0;
    @(negedge clk);
    check("grant_fall", 32'(grant), 32'd0);
    check("valid_rise", 32'(sum_valid), 32'd1);
    check("busy_resp", 32'(busy), 32'd1);
    @(negedge clk);
    check("valid_fall", 32'(sum_valid), 32'd0);
    check("busy_idle", 32'(busy), 32'd0);
  endtask

  initial begin
    int t0, t1;
    n_chk = 0;
    n_bad = 0;
    rst   = 1'b1;
    req   = '0;
    a_in  = '0;
    b_in  = '0;
    repeat (2) @(negedge clk);
    check("rst_grant", 32'(grant), 32'd0);
    check("rst_sum", 32'(sum_out), 32'd0);
    check("rst_valid", 32'(sum_valid), 32'd0);
    check("rst_id", 32'(sum_id), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single request
    set_ops(0, 16'd2, 16'd5);
    req = 4'b0001;
    issue(0, t0);

    // Wrap-around and plain add on requester 1
    set_ops(1, 16'hFFFF, 16'h0001);
    req = 4'b0010;
    issue(1, t0);
    set_ops(1, 16'd15, 16'd1);
    req = 4'b0010;
    issue(1, t0);

    // Full contention after reset: 0,1,2,3 each 3 cycles apart
    do_reset();
    set_ops(0, 16'd14, 16'd1);
    set_ops(1, 16'd16, 16'd1);
    set_ops(2, 16'd17, 16'd5);
    set_ops(3, 16'd0, 16'd0);
    req = 4'b1111;
    issue(0, t0);
    for (int w = 1; w < N; w++) begin
      issue(w, t1);
      check("grant_spacing", 32'(t1 - t0), 32'd3);
      t0 = t1;
    end

    // Round-robin pointer
    set_ops(2, 16'h1234, 16'h1111);
    req = 4'b0100;
    issue(2, t0);
    set_ops(1, 16'h00AA, 16'h0055);
    set_ops(3, 16'h8000, 16'h8001);
    req = 4'b1010;
    issue(3, t0);
    req = 4'b0010;
    issue(1, t0);

    // Reset during CALC discards the operation
    set_ops(0, 16'd100, 16'd200);
    req = 4'b0001;
    @(posedge clk);
    @(negedge clk);
    check("mid_grant", 32'(grant), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_grant", 32'(grant), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sum", 32'(sum_out), 32'd0);
    check("mid_rst_valid", 32'(sum_valid), 32'd0);
    @(negedge clk);
    check("mid_rst_novalid", 32'(sum_valid), 32'd0);
    rst = 1'b0;
    set_ops(0, 16'd7, 16'd9);
    req = 4'b1111;
    issue(0, t0);
    req = '0;

    // Idle: nothing moves
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_grant", 32'(grant), 32'd0);
      check("idle_valid", 32'(sum_valid), 32'd0);
      check("idle_busy", 32'(busy), 32'd0);
    end

    // Request raised only during CALC/RESP is never granted
    set_ops(0, 16'd3, 16'd4);
    req = 4'b0001;
    begin
      exp_t e;
      e.id  = 0;
      e.sum = 16'd7;
      sb.push_back(e);
    end
    @(posedge clk);
    @(negedge clk);
    check("ign_grant0", 32'(grant), 32'd1);
    req = 4'b0010;
    @(negedge clk);
    req = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("ign_no_grant", 32'(grant), 32'd0);
    end

    for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
    check("sb_drain", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
